logic_gate_unit: RTL and testbench
==================================

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each operand and of the result (1..64).
REQ-002 Parameter NUM_IN, default 2, number of operands per beat (2..8).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port op  input  3  operation select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110/111 PASS (operand 0).
REQ-006 Port acc_en  input  1  1 = accumulate beats until in_last; 0 = one result per beat.
REQ-007 Port in_valid  input  1  input beat valid.
REQ-008 Port in_ready  output  1  unit accepts a beat when in_valid && in_ready.
REQ-009 Port in_data  input  NUM_IN*WIDTH  operands; operand k at bits [k*WIDTH +: WIDTH].
REQ-010 Port in_last  input  1  final beat of an accumulate burst; ignored when acc_en=0.
REQ-011 Port out_valid  output  1  result valid.
REQ-012 Port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-013 Port out_data  output  WIDTH  registered result.

Function
REQ-014 Beat reduce: bitwise base op (AND/OR/XOR) across all NUM_IN operands; NAND/NOR/XNOR use base AND/OR/XOR, inverted once at output only.
REQ-015 States IDLE, ACC, HOLD; ACC reachable only with acc_en=1.
REQ-016 op and acc_en sampled on the accepted beat in IDLE and held in op_q/acc_q until burst ends; changes mid-burst ignored.
REQ-017 IDLE, acc_en=0: accepted beat -> out_data = reduce result, out_valid=1 next cycle; latency exactly 1 cycle; state -> HOLD.
REQ-018 IDLE, acc_en=1, in_last=0: accumulator <= base-reduce of beat; state -> ACC; no output.
REQ-019 IDLE, acc_en=1, in_last=1: single-beat burst, behaves as REQ-017.
REQ-020 ACC: each accepted beat combines accumulator with beat reduce using base op; in_last=1 beat loads out_data (inverted for NAND/NOR/XNOR), out_valid=1 next cycle, -> HOLD.
REQ-021 PASS op in accumulate mode: result is operand 0 of the last beat.
REQ-022 in_ready = 1 in IDLE and ACC when out_valid=0 or out_ready=1; back-to-back beats at full rate when out_ready held high.
REQ-023 HOLD: out_data and out_valid stable until out_ready=1; on handshake with simultaneous accepted input, new result loads same edge (no bubble), else -> IDLE with out_valid=0.
REQ-024 in_valid=0 cycles inside a burst leave accumulator and state unchanged.
REQ-025 out_data shall not change while out_valid=1 and out_ready=0.

Reset
REQ-026 rst_n low asynchronously forces state=IDLE, out_valid=0, out_data=0, accumulator=0, op_q=0, acc_q=0.
REQ-027 Reset mid-burst discards partial accumulation; no result emitted for that burst.
REQ-028 in_ready=0 while rst_n low; first beat accepted on first rising edge after release.

Configuration
REQ-029 Macro LOGIC_GATE_UNIT_PARITY_EN defined: extra port out_parity output 1 = even parity (XOR of all out_data bits), registered with out_data, reset 0.
REQ-030 Macro undefined: out_parity port and its logic absent; all other behaviour identical.

Verification
REQ-031 WIDTH=8, NUM_IN=2, op=OR, acc_en=0, operands 0x0F,0xF0, out_ready=1 -> out_data=0xFF, out_valid one cycle after accept.
REQ-032 NUM_IN=4, op=NAND, operands 0xFF,0xFF,0xFF,0x7F -> out_data=0x80.
REQ-033 acc_en=1, op=XOR, 3 beats (2 operands each) 0x01^0x02, 0x04^0x00, 0x08^0x00 last -> single result 0x0F; no output before last.
REQ-034 out_ready=0 for 5 cycles after result -> out_data stable, in_ready=0; out_ready=1 with new beat -> next result next cycle, no bubble.
REQ-035 rst_n asserted after 2 beats of an OR burst -> out_valid=0 immediately; fresh 1-beat burst 0x00,0x00 after release -> 0x00 (no stale bits).
REQ-036 PARITY_EN defined, result 0x07 -> out_parity=1; result 0x03 -> out_parity=0.

Source files
------------

// File: rtl/logic_gate_unit.sv
// Streaming bitwise reduce unit (AND/OR/XOR, inverted forms, PASS) with burst accumulation.
// Define LOGIC_GATE_UNIT_PARITY_EN to add a registered even-parity output.
module logic_gate_unit #(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2:0]              op,
   input  logic                    acc_en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data
`ifdef LOGIC_GATE_UNIT_PARITY_EN
   ,
   output logic                    out_parity
`endif
);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [2:0]       op_q;
   logic             acc_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic             fire;
   logic             start;
   logic             last_beat;
   logic [2:0]       cur_op;
   logic             cur_acc;
   logic             use_and;
   logic             use_or;
   logic             use_xor;
   logic             inv;
   logic             pass;
   logic [WIDTH-1:0] op0;
   logic [WIDTH-1:0] red;
   logic [WIDTH-1:0] comb;
   logic [WIDTH-1:0] fin;

   assign out_valid = (state == HOLD);
   assign in_ready  = rst_n & (~out_valid | out_ready);
   assign fire      = in_valid & in_ready;
   // A beat accepted outside ACC opens a new burst and samples op/acc_en.
   assign start     = fire & (state != ACC);
   assign cur_op    = start ? op : op_q;
   assign cur_acc   = start ? acc_en : acc_q;
   assign last_beat = ~cur_acc | in_last;
   assign op0       = in_data[WIDTH-1:0];

   always_comb begin
      use_and = 1'b0;
      use_or  = 1'b0;
      use_xor = 1'b0;
      inv     = 1'b0;
      pass    = 1'b0;
      unique case (1'b1)
         (cur_op == 3'd0): use_and = 1'b1;
         (cur_op == 3'd1): use_or  = 1'b1;
         (cur_op == 3'd2): use_xor = 1'b1;
         (cur_op == 3'd3): begin use_and = 1'b1; inv = 1'b1; end
         (cur_op == 3'd4): begin use_or  = 1'b1; inv = 1'b1; end
         (cur_op == 3'd5): begin use_xor = 1'b1; inv = 1'b1; end
         default:          pass = 1'b1;
      endcase
   end

   always_comb begin
      red = op0;
      for (int k = 1; k < NUM_IN; k++) begin
         unique case (1'b1)
            use_and: red = red & in_data[k*WIDTH +: WIDTH];
            use_or:  red = red | in_data[k*WIDTH +: WIDTH];
            use_xor: red = red ^ in_data[k*WIDTH +: WIDTH];
            default: ;
         endcase
      end
      comb = red;
      if (!start) begin
         unique case (1'b1)
            use_and: comb = acc & red;
            use_or:  comb = acc | red;
            use_xor: comb = acc ^ red;
            default: ;
         endcase
      end
      if (pass) comb = op0;
      fin = inv ? ~comb : comb;
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      data_nxt  = out_data;
      if (out_valid && out_ready) state_nxt = IDLE;
      if (fire) begin
         if (last_beat) begin
            data_nxt  = fin;
            state_nxt = HOLD;
         end else begin
            acc_nxt   = comb;
            state_nxt = ACC;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= '0;
         out_data <= '0;
         op_q     <= 3'd0;
         acc_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         out_data <= data_nxt;
         if (start) begin
            op_q  <= op;
            acc_q <= acc_en;
         end
      end
   end

`ifdef LOGIC_GATE_UNIT_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_parity <= 1'b0;
      else        out_parity <= ^data_nxt;
   end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: vector tables, corner sequences and a
// randomized run against a burst-level reference model.
module tb_logic_gate_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  op = 3'd0;
   logic        acc_en = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;

   logic [2:0]  op4 = 3'd0;
   logic        in4_valid = 1'b0;
   logic        in4_ready;
   logic [31:0] in4_data = '0;
   logic        out4_valid;
   logic [7:0]  out4_data;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
   logic        out_parity;
   logic        out4_parity;
`endif

   always #5 clk = ~clk;

   logic_gate_unit #(.WIDTH(8), .NUM_IN(2)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .acc_en(acc_en),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data)
`ifdef LOGIC_GATE_UNIT_PARITY_EN
      , .out_parity(out_parity)
`endif
   );

   logic_gate_unit #(.WIDTH(8), .NUM_IN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .op(op4), .acc_en(1'b0),
      .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data),
      .in_last(1'b0), .out_valid(out4_valid), .out_ready(1'b1),
      .out_data(out4_data)
`ifdef LOGIC_GATE_UNIT_PARITY_EN
      , .out_parity(out4_parity)
`endif
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collects every operand of a burst, reduces at the end.
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_inburst;
   logic [2:0] m_op;
   logic       m_acc;
   logic [7:0] ops[$];

   function automatic logic [7:0] eval_burst(input logic [2:0] o,
                                             input logic [7:0] last0);
      logic [7:0] r;
      if (o >= 3'd6) return last0;
      r = ops[0];
      for (int i = 1; i < ops.size(); i++) begin
         case (int'(o) % 3)
            0:       r = r & ops[i];
            1:       r = r | ops[i];
            default: r = r ^ ops[i];
         endcase
      end
      if (o >= 3'd3) r = ~r;
      return r;
   endfunction

   task automatic model_reset();
      m_valid   = 1'b0;
      m_data    = 8'h00;
      m_inburst = 1'b0;
      m_op      = 3'd0;
      m_acc     = 1'b0;
      ops.delete();
   endtask

   task automatic model_edge();
      logic f;
      f = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (f) begin
         if (!m_inburst) begin
            m_op      = op;
            m_acc     = acc_en;
            m_inburst = 1'b1;
         end
         ops.push_back(in_data[7:0]);
         ops.push_back(in_data[15:8]);
         if (!m_acc || in_last) begin
            m_data    = eval_burst(m_op, in_data[7:0]);
            m_valid   = 1'b1;
            m_inburst = 1'b0;
            ops.delete();
         end
      end
   endtask

   task automatic tick();
      #2;
      chk("in_ready", in_ready, (!m_valid || out_ready));
      @(posedge clk);
      model_edge();
      #1;
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("out_data", out_data, m_data);
`ifdef LOGIC_GATE_UNIT_PARITY_EN
      if (m_valid) chk("out_parity", out_parity, ^m_data);
`endif
   endtask

   task automatic beat(input logic [2:0] o, input logic a, input logic l,
                       input logic [7:0] d0, input logic [7:0] d1);
      op       = o;
      acc_en   = a;
      in_last  = l;
      in_data  = {d1, d0};
      in_valid = 1'b1;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
   } vec_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] d;
      logic [7:0]  exp;
   } vec4_t;

   vec_t  tbl[8];
   vec4_t tbl4[4];

   initial begin
      tbl[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30};
      tbl[1] = '{3'd1, 8'h0F, 8'hF0, 8'hFF};
      tbl[2] = '{3'd2, 8'hAA, 8'hFF, 8'h55};
      tbl[3] = '{3'd3, 8'hF0, 8'h3C, 8'hCF};
      tbl[4] = '{3'd4, 8'h0F, 8'h30, 8'hC0};
      tbl[5] = '{3'd5, 8'hAA, 8'h0F, 8'h5A};
      tbl[6] = '{3'd6, 8'h12, 8'h34, 8'h12};
      tbl[7] = '{3'd7, 8'h9A, 8'h00, 8'h9A};
      tbl4[0] = '{3'd3, 32'h7FFF_FFFF, 8'h80};
      tbl4[1] = '{3'd1, 32'h0804_0201, 8'h0F};
      tbl4[2] = '{3'd2, 32'h0F07_0301, 8'h0A};
      tbl4[3] = '{3'd0, 32'hF33C_FFF0, 8'h30};

      model_reset();
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst4_out_valid", out4_valid, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single-beat table; odd rows use acc_en=1 with in_last=1.
      for (int i = 0; i < 8; i++) begin
         beat(tbl[i].op, i[0], i[0], tbl[i].a, tbl[i].b);
         tick();
         chk("tbl_valid", out_valid, 1'b1);
         chk("tbl_data", out_data, tbl[i].exp);
         in_valid = 1'b0;
         tick();
      end

      for (int i = 0; i < 4; i++) begin
         op4       = tbl4[i].op;
         in4_data  = tbl4[i].d;
         in4_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("tbl4_valid", out4_valid, 1'b1);
         chk("tbl4_data", out4_data, tbl4[i].exp);
         in4_valid = 1'b0;
         @(posedge clk);
         #1;
         chk("tbl4_idle", out4_valid, 1'b0);
      end

      // XOR burst with a gap and ignored mid-burst op/acc_en changes.
      beat(3'd2, 1'b1, 1'b0, 8'h01, 8'h02);
      tick();
      chk("burst_b1_quiet", out_valid, 1'b0);
      beat(3'd0, 1'b0, 1'b0, 8'h04, 8'h00);
      tick();
      chk("burst_b2_quiet", out_valid, 1'b0);
      in_valid = 1'b0;
      tick();
      chk("burst_gap_quiet", out_valid, 1'b0);
      beat(3'd1, 1'b1, 1'b1, 8'h08, 8'h00);
      tick();
      chk("burst_result", out_data, 8'h0F);
      in_valid = 1'b0;
      tick();

      // Back-pressure then no-bubble reload.
      out_ready = 1'b1;
      beat(3'd1, 1'b0, 1'b0, 8'h03, 8'h30);
      tick();
      chk("bp_first", out_data, 8'h33);
      beat(3'd1, 1'b0, 1'b0, 8'h44, 8'h00);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_data", out_data, 8'h33);
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_next_valid", out_valid, 1'b1);
      chk("bp_next_data", out_data, 8'h44);
      in_valid = 1'b0;
      tick();

      // PASS in accumulate mode takes operand 0 of the last beat.
      beat(3'd6, 1'b1, 1'b0, 8'h11, 8'h22);
      tick();
      beat(3'd6, 1'b1, 1'b1, 8'h33, 8'h44);
      tick();
      chk("pass_acc", out_data, 8'h33);
      in_valid = 1'b0;
      tick();

      // Reset in the middle of an OR burst.
      beat(3'd1, 1'b1, 1'b0, 8'h0F, 8'hF0);
      tick();
      beat(3'd1, 1'b1, 1'b0, 8'h81, 8'h18);
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_ready", in_ready, 1'b0);
      chk("midrst_data", out_data, 8'h00);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      beat(3'd1, 1'b1, 1'b1, 8'h00, 8'h00);
      tick();
      chk("postrst_valid", out_valid, 1'b1);
      chk("postrst_data", out_data, 8'h00);
      in_valid = 1'b0;
      tick();

`ifdef LOGIC_GATE_UNIT_PARITY_EN
      beat(3'd1, 1'b0, 1'b0, 8'h07, 8'h00);
      tick();
      chk("parity_07", out_parity, 1'b1);
      beat(3'd1, 1'b0, 1'b0, 8'h03, 8'h00);
      tick();
      chk("parity_03", out_parity, 1'b0);
      in_valid = 1'b0;
      tick();
`endif

      for (int i = 0; i < 800; i++) begin
         op        = 3'($urandom_range(0, 7));
         acc_en    = 1'($urandom_range(0, 1));
         in_last   = ($urandom_range(0, 2) == 0);
         in_data   = 16'($urandom);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
